ntt_butterfly_scheduler: RTL

Issue scheduler for the shared NTT butterfly datapath. It accepts butterfly requests tagged with a butterfly variant (generic, W0, W0_W2), each of which has a different fixed pipeline latency. It issues at most one request per cycle into the datapath and guarantees that no two results leave the datapath in the same cycle. It also enforces downstream buffer credits and emits a tag stream aligned cycle-exactly with the datapath outputs, plus a pass-complete pulse.

---
 rtl/ntt_butterfly_scheduler_if.sv | 29 ++
 rtl/ntt_butterfly_scheduler.sv | 100 ++++++++++
 2 files changed

// File: rtl/ntt_butterfly_scheduler_if.sv
// rtl/ntt_butterfly_scheduler_if.sv - request, issue, result and control signals of the butterfly scheduler
interface ntt_butterfly_scheduler_if #(
   parameter int TAG_W = 16
);
   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_mode;
   logic [TAG_W-1:0] in_tag;
   logic             in_last;
   logic             issue_valid;
   logic [1:0]       issue_mode;
   logic             out_valid;
   logic [TAG_W-1:0] out_tag;
   logic             credit_ret;
   logic             done;
   logic             err_mode;
   logic             busy;

   modport master (
      output start, in_valid, in_mode, in_tag, in_last, credit_ret,
      input  in_ready, issue_valid, issue_mode, out_valid, out_tag, done, err_mode, busy
   );

   modport slave (
      input  start, in_valid, in_mode, in_tag, in_last, credit_ret,
      output in_ready, issue_valid, issue_mode, out_valid, out_tag, done, err_mode, busy
   );
endinterface

// File: rtl/ntt_butterfly_scheduler.sv
// rtl/ntt_butterfly_scheduler.sv - exit-slot scheduler for the shared NTT butterfly datapath
module ntt_butterfly_scheduler #(
   parameter int TAG_W       = 16,
   parameter int LAT_GENERIC = 28,
   parameter int LAT_W0      = 6,
   parameter int LAT_W0_W2   = 14,
   parameter int CREDITS     = 32
) (
   input logic clk,
   input logic rst,
   ntt_butterfly_scheduler_if.slave bus
);
   localparam int MAXL_AB = (LAT_GENERIC > LAT_W0) ? LAT_GENERIC : LAT_W0;
   localparam int MAXL    = (MAXL_AB > LAT_W0_W2) ? MAXL_AB : LAT_W0_W2;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state, state_nx;
   // occ[k] set means the result leaves the datapath k cycles from now; bit 0 is the current output
   logic [MAXL-1:0]  occ, occ_shift, occ_nx;
   logic [TAG_W-1:0] tag_slot [1:MAXL-1];
   logic [TAG_W-1:0] out_tag_q;
   logic [7:0]       credit_cnt;
   logic             err_q;
   logic             slot_taken, accept, issue;

   assign occ_shift = {1'b0, occ[MAXL-1:1]};

   always_comb begin
      slot_taken = occ_shift[LAT_GENERIC-1];
      case (bus.in_mode)
         2'd1:    slot_taken = occ_shift[LAT_W0-1];
         2'd2:    slot_taken = occ_shift[LAT_W0_W2-1];
         default: slot_taken = occ_shift[LAT_GENERIC-1];
      endcase
   end

   assign bus.in_ready    = (state == RUN) && (credit_cnt != 8'd0) && !slot_taken;
   assign accept          = bus.in_valid && bus.in_ready;
   assign issue           = accept && (bus.in_mode != 2'd3);
   assign bus.issue_valid = issue;
   assign bus.issue_mode  = issue ? bus.in_mode : 2'd0;
   assign bus.out_valid   = occ[0];
   assign bus.out_tag     = out_tag_q;
   assign bus.done        = (state == DONE);
   assign bus.busy        = (state != IDLE);
   assign bus.err_mode    = err_q;

   always_comb begin
      occ_nx = occ_shift;
      if (issue) begin
         case (bus.in_mode)
            2'd1:    occ_nx[LAT_W0-1]      = 1'b1;
            2'd2:    occ_nx[LAT_W0_W2-1]   = 1'b1;
            default: occ_nx[LAT_GENERIC-1] = 1'b1;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = RUN;
         RUN:     if (accept && bus.in_last) state_nx = DRAIN;
         DRAIN:   if (occ_shift == '0) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         occ        <= '0;
         out_tag_q  <= '0;
         credit_cnt <= 8'(CREDITS);
         err_q      <= 1'b0;
         for (int k = 1; k < MAXL; k++) tag_slot[k] <= '0;
      end else begin
         state <= state_nx;
         occ   <= occ_nx;
         if (occ[1]) out_tag_q <= tag_slot[1];
         for (int k = 1; k < MAXL - 1; k++) tag_slot[k] <= tag_slot[k+1];
         tag_slot[MAXL-1] <= '0;
         if (issue) begin
            case (bus.in_mode)
               2'd1:    tag_slot[LAT_W0-1]      <= bus.in_tag;
               2'd2:    tag_slot[LAT_W0_W2-1]   <= bus.in_tag;
               default: tag_slot[LAT_GENERIC-1] <= bus.in_tag;
            endcase
         end
         // a return arriving with an issue cancels out; returns never push past the full pool
         if (issue && !bus.credit_ret)
            credit_cnt <= credit_cnt - 8'd1;
         else if (!issue && bus.credit_ret && credit_cnt != 8'(CREDITS))
            credit_cnt <= credit_cnt + 8'd1;
         if (accept && bus.in_mode == 2'd3) err_q <= 1'b1;
      end
   end
endmodule
